cellrv32_cpu_cp_vector_vis: RTL and testbench

- Vector issue stage, directly upstream of the vector execution stage.
- Accepts one decoded vector micro-op per cycle and reads both source operands from the vector register file.
- Resolves RAW hazards with a per-register in-flight scoreboard, selecting operands from the EX1/EX4 forwarding points or the writeback bus when possible.
- Drives a registered valid/ready issue interface into execution.

---
 rtl/cellrv32_cpu_cp_vector_vis_pkg.sv | 68 ++++++
 rtl/cellrv32_cpu_cp_vector_vis_scoreboard.sv | 82 ++++++++
 rtl/cellrv32_cpu_cp_vector_vis.sv | 176 +++++++++++++++++
 tb/tb_cellrv32_cpu_cp_vector_vis.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cellrv32_cpu_cp_vector_vis_pkg.sv
// -----------------------------------------------------------------------------
// cellrv32_cpu_cp_vector_vis_pkg
// Shared types for the vector issue stage: the decoded micro-op arriving from
// decode, the per-lane operand bundle and the per-op control info handed to
// the vector execution stage, plus the funct3 operand-category encodings.
// Widths here fix the struct layouts; the issue-stage module parameters must
// keep their default values so that they agree with these layouts.
// -----------------------------------------------------------------------------
package cellrv32_cpu_cp_vector_vis_pkg;

    localparam int VIS_REGS  = 32;
    localparam int VIS_LANES = 8;
    localparam int VIS_DW    = 32;

    localparam int VREG_W    = $clog2(VIS_REGS);
    // Longest vector (LMUL=8) spans eight micro-ops of VIS_LANES elements.
    localparam int VL_MAX    = 8 * VIS_LANES;
    // One extra bit so vl == VL_MAX and element indices never wrap.
    localparam int VL_W      = $clog2(VL_MAX) + 1;
    localparam int UOP_IDX_W = $clog2(VL_MAX / VIS_LANES);

    // funct3 operand categories of the OP-V major opcode
    localparam logic [2:0] funct3_opivv_c = 3'b000;
    localparam logic [2:0] funct3_opfvv_c = 3'b001;
    localparam logic [2:0] funct3_opmvv_c = 3'b010;
    localparam logic [2:0] funct3_opivi_c = 3'b011;
    localparam logic [2:0] funct3_opivx_c = 3'b100;
    localparam logic [2:0] funct3_opfvx_c = 3'b101;
    localparam logic [2:0] funct3_opmvx_c = 3'b110;
    localparam logic [2:0] funct3_opcfg_c = 3'b111;

    typedef struct packed {
        logic [VREG_W-1:0]    src1;
        logic [VREG_W-1:0]    src2;
        logic [VREG_W-1:0]    dst;
        logic [5:0]           funct6;
        logic [2:0]           funct3;
        logic [2:0]           frm;
        logic [4:0]           vfunary;
        logic [VL_W-1:0]      vl;
        logic                 vm;
        logic                 is_rdc;
        logic                 head_uop;
        logic                 end_uop;
        logic [UOP_IDX_W-1:0] uop_idx;
        logic [VIS_DW-1:0]    scalar;
    } to_vector_issue;

    typedef struct packed {
        logic              valid;
        logic              mask;
        logic [VIS_DW-1:0] data1;
        logic [VIS_DW-1:0] data2;
    } to_vector_exec;

    typedef struct packed {
        logic [VREG_W-1:0] dst;
        logic [5:0]        funct6;
        logic [2:0]        funct3;
        logic [2:0]        frm;
        logic [4:0]        vfunary;
        logic [VL_W-1:0]   vl;
        logic              is_rdc;
        logic              head_uop;
        logic              end_uop;
    } to_vector_exec_info;

endpackage

// File: rtl/cellrv32_cpu_cp_vector_vis_scoreboard.sv
// -----------------------------------------------------------------------------
// cellrv32_cpu_cp_vector_vis_scoreboard
// One saturating in-flight write counter per architectural vector register.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   inc_i / inc_addr_i         micro-op issued that will write inc_addr_i
//   dec_i / dec_addr_i         writeback of dec_addr_i retired this cycle
//   rd_src1/src2/dst_addr_i    registers whose counts are read
//   src1/src2/dst_cnt_o        combinational counts for those registers
//   all_zero_o                 no register has a write in flight
// -----------------------------------------------------------------------------
module cellrv32_cpu_cp_vector_vis_scoreboard
    import cellrv32_cpu_cp_vector_vis_pkg::*;
#(
    parameter  int VECTOR_REGISTERS = VIS_REGS,
    parameter  int SB_CNT_WIDTH     = 2,
    localparam int RA_W             = $clog2(VECTOR_REGISTERS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc_i,
    input  logic [RA_W-1:0]         inc_addr_i,
    input  logic                    dec_i,
    input  logic [RA_W-1:0]         dec_addr_i,
    input  logic [RA_W-1:0]         rd_src1_addr_i,
    input  logic [RA_W-1:0]         rd_src2_addr_i,
    input  logic [RA_W-1:0]         rd_dst_addr_i,
    output logic [SB_CNT_WIDTH-1:0] src1_cnt_o,
    output logic [SB_CNT_WIDTH-1:0] src2_cnt_o,
    output logic [SB_CNT_WIDTH-1:0] dst_cnt_o,
    output logic                    all_zero_o
);

    logic [SB_CNT_WIDTH-1:0] cnt_q [VECTOR_REGISTERS];
    logic [SB_CNT_WIDTH-1:0] cnt_d [VECTOR_REGISTERS];

    // Increment and decrement of the same register cancel; both ends clamp
    // so an illegal decrement at zero cannot wrap the counter.
    function automatic logic [SB_CNT_WIDTH-1:0] cnt_step(
        input logic [SB_CNT_WIDTH-1:0] cnt,
        input logic                    inc,
        input logic                    dec
    );
        logic [SB_CNT_WIDTH-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && cnt != '1) nxt = cnt + SB_CNT_WIDTH'(1);
        if (dec && !inc && cnt != '0) nxt = cnt - SB_CNT_WIDTH'(1);
        return nxt;
    endfunction

    always_comb begin
        for (int r = 0; r < VECTOR_REGISTERS; r++) begin
            cnt_d[r] = cnt_step(cnt_q[r],
                                inc_i && (inc_addr_i == RA_W'(r)),
                                dec_i && (dec_addr_i == RA_W'(r)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < VECTOR_REGISTERS; r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < VECTOR_REGISTERS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

    always_comb begin
        all_zero_o = 1'b1;
        for (int r = 0; r < VECTOR_REGISTERS; r++) begin
            if (cnt_q[r] != '0) all_zero_o = 1'b0;
        end
    end

    assign src1_cnt_o = cnt_q[rd_src1_addr_i];
    assign src2_cnt_o = cnt_q[rd_src2_addr_i];
    assign dst_cnt_o  = cnt_q[rd_dst_addr_i];

    // A writeback must always correspond to an earlier issued micro-op.
    dec_at_zero_a: assert property (@(posedge clk) disable iff (!rst_n)
        (dec_i && !(inc_i && inc_addr_i == dec_addr_i)) |-> (cnt_q[dec_addr_i] != '0));

endmodule

// File: rtl/cellrv32_cpu_cp_vector_vis.sv
// -----------------------------------------------------------------------------
// cellrv32_cpu_cp_vector_vis
// Vector issue stage. Takes one decoded micro-op per cycle, reads both sources
// from the vector register file, resolves RAW hazards against the in-flight
// scoreboard using the EX1/EX4 forward points and the writeback bus, and
// presents a registered valid/ready micro-op to the execution stage.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_i/ready_o, uop_i, mask_i  micro-op handshake from decode, v0 bits
//   rf_addr_a/b_o, rf_data_a/b_i    register-file read (same-cycle data)
//   frw_a_*                         EX1 forward point (per-lane enables)
//   frw_b_*                         EX4 forward point
//   wr_*                            writeback bus, also retires scoreboard
//   valid_o/ready_i, exec_data_o,   issue handshake and payload to execution
//   exec_info_o
//   vis_idle_o                      nothing held and nothing in flight
// -----------------------------------------------------------------------------
module cellrv32_cpu_cp_vector_vis
    import cellrv32_cpu_cp_vector_vis_pkg::*;
#(
    parameter  int VECTOR_REGISTERS = VIS_REGS,
    parameter  int VECTOR_LANES     = VIS_LANES,
    parameter  int DATA_WIDTH       = VIS_DW,
    parameter  int SB_CNT_WIDTH     = 2,
    localparam int RA_W             = $clog2(VECTOR_REGISTERS),
    localparam int LW               = VECTOR_LANES * DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  to_vector_issue                   uop_i,
    input  logic [VECTOR_LANES-1:0]          mask_i,
    output logic [RA_W-1:0]                  rf_addr_a_o,
    output logic [RA_W-1:0]                  rf_addr_b_o,
    input  logic [LW-1:0]                    rf_data_a_i,
    input  logic [LW-1:0]                    rf_data_b_i,
    input  logic [VECTOR_LANES-1:0]          frw_a_en_i,
    input  logic [RA_W-1:0]                  frw_a_addr_i,
    input  logic [LW-1:0]                    frw_a_data_i,
    input  logic [VECTOR_LANES-1:0]          frw_b_en_i,
    input  logic [RA_W-1:0]                  frw_b_addr_i,
    input  logic [LW-1:0]                    frw_b_data_i,
    input  logic [VECTOR_LANES-1:0]          wr_en_i,
    input  logic [RA_W-1:0]                  wr_addr_i,
    input  logic [LW-1:0]                    wr_data_i,
    output logic                             valid_o,
    output to_vector_exec [VECTOR_LANES-1:0] exec_data_o,
    output to_vector_exec_info               exec_info_o,
    input  logic                             ready_i,
    output logic                             vis_idle_o
);

    logic [SB_CNT_WIDTH-1:0] src1_cnt, src2_cnt, dst_cnt;
    logic sb_all_zero;
    logic src1_used, hit_src1, hit_src2;
    logic hazard, free, accept;

    to_vector_exec [VECTOR_LANES-1:0] lane_p0;
    to_vector_exec_info               info_p0;

    logic                             vld_p1;
    to_vector_exec [VECTOR_LANES-1:0] lane_p1;
    to_vector_exec_info               info_p1;

    // A source with one write in flight is usable only if that write is
    // visible on a forward point or the writeback bus this cycle.
    function automatic logic src_blocked(
        input logic [SB_CNT_WIDTH-1:0] cnt,
        input logic                    hit
    );
        return (cnt > SB_CNT_WIDTH'(1)) || ((cnt == SB_CNT_WIDTH'(1)) && !hit);
    endfunction

    // ---- stage p0: register read, hazard check, operand select ----
    assign rf_addr_a_o = uop_i.src1;
    assign rf_addr_b_o = uop_i.src2;

    assign src1_used = !(uop_i.funct3 inside {funct3_opivx_c, funct3_opivi_c,
                                              funct3_opmvx_c, funct3_opfvx_c});

    assign hit_src1 = ((|frw_a_en_i) && (frw_a_addr_i == uop_i.src1)) ||
                      ((|frw_b_en_i) && (frw_b_addr_i == uop_i.src1)) ||
                      ((|wr_en_i)    && (wr_addr_i    == uop_i.src1));
    assign hit_src2 = ((|frw_a_en_i) && (frw_a_addr_i == uop_i.src2)) ||
                      ((|frw_b_en_i) && (frw_b_addr_i == uop_i.src2)) ||
                      ((|wr_en_i)    && (wr_addr_i    == uop_i.src2));

    assign hazard = (src1_used && src_blocked(src1_cnt, hit_src1)) ||
                    src_blocked(src2_cnt, hit_src2) ||
                    (dst_cnt == '1);
    assign free    = !vld_p1 || ready_i;
    assign ready_o = free && !hazard;
    assign accept  = valid_i && ready_o;

    always_comb begin
        lane_p0 = '0;
        for (int k = 0; k < VECTOR_LANES; k++) begin
            // Fallback first, then overwrite in rising priority: wr < frw_b < frw_a.
            lane_p0[k].data1 = rf_data_a_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (wr_en_i[k] && (wr_addr_i == uop_i.src1))
                lane_p0[k].data1 = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (frw_b_en_i[k] && (frw_b_addr_i == uop_i.src1))
                lane_p0[k].data1 = frw_b_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (frw_a_en_i[k] && (frw_a_addr_i == uop_i.src1))
                lane_p0[k].data1 = frw_a_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (!src1_used)
                lane_p0[k].data1 = uop_i.scalar;

            lane_p0[k].data2 = rf_data_b_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (wr_en_i[k] && (wr_addr_i == uop_i.src2))
                lane_p0[k].data2 = wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (frw_b_en_i[k] && (frw_b_addr_i == uop_i.src2))
                lane_p0[k].data2 = frw_b_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            if (frw_a_en_i[k] && (frw_a_addr_i == uop_i.src2))
                lane_p0[k].data2 = frw_a_data_i[k*DATA_WIDTH +: DATA_WIDTH];

            lane_p0[k].valid = (VL_W'(uop_i.uop_idx) * VL_W'(VECTOR_LANES) + VL_W'(k))
                               < uop_i.vl;
            lane_p0[k].mask  = uop_i.vm ? 1'b1 : mask_i[k];
        end
    end

    always_comb begin
        info_p0          = '0;
        info_p0.dst      = uop_i.dst;
        info_p0.funct6   = uop_i.funct6;
        info_p0.funct3   = uop_i.funct3;
        info_p0.frm      = uop_i.frm;
        info_p0.vfunary  = uop_i.vfunary;
        info_p0.vl       = uop_i.vl;
        info_p0.is_rdc   = uop_i.is_rdc;
        info_p0.head_uop = uop_i.head_uop;
        info_p0.end_uop  = uop_i.end_uop;
    end

    cellrv32_cpu_cp_vector_vis_scoreboard #(
        .VECTOR_REGISTERS (VECTOR_REGISTERS),
        .SB_CNT_WIDTH     (SB_CNT_WIDTH)
    ) u_scoreboard (
        .clk            (clk),
        .rst_n          (rst_n),
        .inc_i          (accept),
        .inc_addr_i     (uop_i.dst),
        .dec_i          (|wr_en_i),
        .dec_addr_i     (wr_addr_i),
        .rd_src1_addr_i (uop_i.src1),
        .rd_src2_addr_i (uop_i.src2),
        .rd_dst_addr_i  (uop_i.dst),
        .src1_cnt_o     (src1_cnt),
        .src2_cnt_o     (src2_cnt),
        .dst_cnt_o      (dst_cnt),
        .all_zero_o     (sb_all_zero)
    );

    // ---- stage p1: issue register towards execution ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            lane_p1 <= '0;
            info_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            lane_p1 <= lane_p0;
            info_p1 <= info_p0;
        end else if (ready_i) begin
            vld_p1  <= 1'b0;
        end
    end

    assign valid_o     = vld_p1;
    assign exec_data_o = lane_p1;
    assign exec_info_o = info_p1;
    assign vis_idle_o  = !vld_p1 && sb_all_zero;

endmodule

// File: tb/tb_cellrv32_cpu_cp_vector_vis.sv
module tb_cellrv32_cpu_cp_vector_vis;
    import cellrv32_cpu_cp_vector_vis_pkg::*;

    localparam int L  = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic valid_i, ready_o, ready_i, valid_o, vis_idle_o;
    to_vector_issue uop_i;
    logic [L-1:0] mask_i;
    logic [4:0] rf_addr_a_o, rf_addr_b_o;
    logic [L*DW-1:0] rf_data_a_i, rf_data_b_i;
    logic [L-1:0] frw_a_en_i, frw_b_en_i, wr_en_i;
    logic [4:0] frw_a_addr_i, frw_b_addr_i, wr_addr_i;
    logic [L*DW-1:0] frw_a_data_i, frw_b_data_i, wr_data_i;
    to_vector_exec [L-1:0] exec_data_o;
    to_vector_exec_info exec_info_o;

    int errs = 0;
    int checks = 0;

    cellrv32_cpu_cp_vector_vis dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .uop_i        (uop_i),
        .mask_i       (mask_i),
        .rf_addr_a_o  (rf_addr_a_o),
        .rf_addr_b_o  (rf_addr_b_o),
        .rf_data_a_i  (rf_data_a_i),
        .rf_data_b_i  (rf_data_b_i),
        .frw_a_en_i   (frw_a_en_i),
        .frw_a_addr_i (frw_a_addr_i),
        .frw_a_data_i (frw_a_data_i),
        .frw_b_en_i   (frw_b_en_i),
        .frw_b_addr_i (frw_b_addr_i),
        .frw_b_data_i (frw_b_data_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .valid_o      (valid_o),
        .exec_data_o  (exec_data_o),
        .exec_info_o  (exec_info_o),
        .ready_i      (ready_i),
        .vis_idle_o   (vis_idle_o)
    );

    always #5 clk = ~clk;

    // Register file contents: a distinct value per (register, lane).
    function automatic logic [31:0] rf_val(input logic [4:0] r, input int k);
        return 32'h1000_0000 | (32'(r) << 8) | 32'(k);
    endfunction

    always_comb begin
        rf_data_a_i = '0;
        rf_data_b_i = '0;
        for (int k = 0; k < L; k++) begin
            rf_data_a_i[k*DW +: DW] = rf_val(rf_addr_a_o, k);
            rf_data_b_i[k*DW +: DW] = rf_val(rf_addr_b_o, k);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic to_vector_issue mk(input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [4:0] d, input logic [2:0] f3,
                                          input logic [31:0] sc);
        to_vector_issue u;
        u = '0;
        u.src1 = s1; u.src2 = s2; u.dst = d; u.funct3 = f3;
        u.funct6 = 6'h01; u.vl = VL_W'(8); u.vm = 1'b1;
        u.head_uop = 1'b1; u.end_uop = 1'b1; u.scalar = sc;
        return u;
    endfunction

    function automatic logic [L-1:0] lane_valids();
        logic [L-1:0] v;
        for (int k = 0; k < L; k++) v[k] = exec_data_o[k].valid;
        return v;
    endfunction

    function automatic logic [L-1:0] lane_masks();
        logic [L-1:0] m;
        for (int k = 0; k < L; k++) m[k] = exec_data_o[k].mask;
        return m;
    endfunction

    task automatic tail_row(input int vl, input int idx, input logic vm, input logic [7:0] m,
                            input logic [7:0] ev, input logic [7:0] em, input logic [4:0] d);
        uop_i = mk(5'd2, 5'd3, d, funct3_opivv_c, 32'h0);
        uop_i.vl = VL_W'(vl);
        uop_i.uop_idx = UOP_IDX_W'(idx);
        uop_i.vm = vm;
        mask_i = m;
        valid_i = 1'b1;
        @(negedge clk); chk("tail_rdy", ready_o, 1);
        cyc();
        chk("tail_lvalid", lane_valids(), ev);
        chk("tail_lmask", lane_masks(), em);
        chk("tail_dst", exec_info_o.dst, d);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1; uop_i = '0; mask_i = '0;
        frw_a_en_i = '0; frw_a_addr_i = '0; frw_a_data_i = '0;
        frw_b_en_i = '0; frw_b_addr_i = '0; frw_b_data_i = '0;
        wr_en_i = '0; wr_addr_i = '0; wr_data_i = '0;
        #2;
        chk("rst_valid", valid_o, 0);
        chk("rst_idle", vis_idle_o, 1);
        chk("rst_info", exec_info_o, 0);
        chk("rst_data", exec_data_o[0].data2, 0);
        chk("rst_ready", ready_o, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Independent ops back-to-back
        uop_i = mk(5'd2, 5'd3, 5'd1, funct3_opivv_c, 32'h0); valid_i = 1'b1;
        @(negedge clk); chk("ind_rdy0", ready_o, 1);
        cyc();
        chk("ind_vld0", valid_o, 1);
        chk("ind_dst0", exec_info_o.dst, 1);
        chk("ind_lv0", lane_valids(), 8'hFF);
        for (int k = 0; k < L; k++) begin
            chk("ind_d1", exec_data_o[k].data1, rf_val(5'd2, k));
            chk("ind_d2", exec_data_o[k].data2, rf_val(5'd3, k));
        end
        uop_i = mk(5'd5, 5'd6, 5'd4, funct3_opivv_c, 32'h0);
        @(negedge clk); chk("ind_rdy1", ready_o, 1);
        cyc();
        chk("ind_vld1", valid_o, 1);
        chk("ind_dst1", exec_info_o.dst, 4);
        for (int k = 0; k < L; k++) chk("ind_d2b", exec_data_o[k].data2, rf_val(5'd6, k));
        chk("ind_d1b", exec_data_o[0].data1, rf_val(5'd5, 0));
        valid_i = 1'b0; wr_en_i = 8'hFF; wr_addr_i = 5'd1;
        cyc();
        wr_addr_i = 5'd4;
        cyc();
        wr_en_i = '0;
        chk("ind_drain_vld", valid_o, 0);
        chk("ind_drain_idle", vis_idle_o, 1);

        // RAW resolved via EX1 forward
        uop_i = mk(5'd2, 5'd3, 5'd1, funct3_opivv_c, 32'h0); valid_i = 1'b1;
        @(negedge clk); chk("fwd_rdy0", ready_o, 1);
        cyc();
        uop_i = mk(5'd2, 5'd1, 5'd8, funct3_opivv_c, 32'h0);
        frw_a_en_i = 8'hFF; frw_a_addr_i = 5'd1; frw_a_data_i = {L{32'hA5A5_A5A5}};
        @(negedge clk); chk("fwd_rdy1", ready_o, 1);
        cyc();
        chk("fwd_vld", valid_o, 1);
        chk("fwd_dst", exec_info_o.dst, 8);
        for (int k = 0; k < L; k++) chk("fwd_d2", exec_data_o[k].data2, 32'hA5A5_A5A5);
        chk("fwd_d1", exec_data_o[3].data1, rf_val(5'd2, 3));
        frw_a_en_i = '0; valid_i = 1'b0; wr_en_i = 8'hFF; wr_addr_i = 5'd8;
        cyc();
        wr_en_i = '0;

        // RAW with no forward: stall until the writeback arrives
        uop_i = mk(5'd2, 5'd1, 5'd9, funct3_opivv_c, 32'h0); valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("raw_stall", ready_o, 0);
            cyc();
        end
        chk("raw_noissue", valid_o, 0);
        wr_en_i = 8'hFF; wr_addr_i = 5'd1; wr_data_i = {L{32'hC3C3_0001}};
        @(negedge clk); chk("raw_rdy", ready_o, 1);
        cyc();
        wr_en_i = '0;
        chk("raw_vld", valid_o, 1);
        chk("raw_dst", exec_info_o.dst, 9);
        for (int k = 0; k < L; k++) chk("raw_d2", exec_data_o[k].data2, 32'hC3C3_0001);
        uop_i = mk(5'd0, 5'd1, 5'd10, funct3_opivx_c, 32'hDEAD_BEEF);
        @(negedge clk); chk("raw_cnt_clear", ready_o, 1);
        cyc();
        chk("sc_vld", valid_o, 1);
        chk("sc_dst", exec_info_o.dst, 10);
        for (int k = 0; k < L; k++) begin
            chk("sc_d1", exec_data_o[k].data1, 32'hDEAD_BEEF);
            chk("sc_d2", exec_data_o[k].data2, rf_val(5'd1, k));
        end

        // Backpressure holds the issued op stable
        ready_i = 1'b0;
        uop_i = mk(5'd11, 5'd12, 5'd13, funct3_opivv_c, 32'h0); valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_rdy", ready_o, 0);
            chk("bp_vld", valid_o, 1);
            chk("bp_dst", exec_info_o.dst, 10);
            chk("bp_d1", exec_data_o[0].data1, 32'hDEAD_BEEF);
            chk("bp_d2", exec_data_o[7].data2, rf_val(5'd1, 7));
            cyc();
        end
        ready_i = 1'b1;
        @(negedge clk); chk("bp_rdy_rel", ready_o, 1);
        cyc();
        chk("bp_vld_next", valid_o, 1);
        chk("bp_dst_next", exec_info_o.dst, 13);
        chk("bp_d1_next", exec_data_o[0].data1, rf_val(5'd11, 0));
        chk("bp_d2_next", exec_data_o[3].data2, rf_val(5'd12, 3));

        // Tail and mask
        tail_row(10, 1, 1'b0, 8'h01, 8'h03, 8'h01, 5'd14);
        tail_row(63, 7, 1'b1, 8'h00, 8'h7F, 8'hFF, 5'd15);
        tail_row(8,  1, 1'b0, 8'hA5, 8'h00, 8'hA5, 5'd16);
        mask_i = '0;

        // Scoreboard saturation, then reset mid-stall
        uop_i = mk(5'd2, 5'd3, 5'd7, funct3_opivv_c, 32'h0); valid_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); chk("sat_rdy", ready_o, 1);
            cyc();
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); chk("sat_stall", ready_o, 0);
            cyc();
        end
        chk("sat_busy", vis_idle_o, 0);
        chk("sat_dst_held", exec_info_o.dst, 7);
        rst_n = 1'b0; valid_i = 1'b0;
        #1;
        chk("mrst_vld", valid_o, 0);
        chk("mrst_idle", vis_idle_o, 1);
        chk("mrst_dst", exec_info_o.dst, 0);
        cyc();
        rst_n = 1'b1; valid_i = 1'b1;
        @(negedge clk); chk("mrst_rdy", ready_o, 1);
        cyc();
        valid_i = 1'b0;
        chk("mrst_issue", valid_o, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
